// File: rtl/mem_tid_pkg.sv
// Shared types, default sizing and elaboration checks for the memory TID allocator.
package mem_tid_pkg;

    localparam int unsigned MemTidWidth          = 4;
    localparam int unsigned MaxOutstandingStores = 7;
    localparam int unsigned MemTidChannels       = 2;
    localparam int unsigned MemTidChIdxWidth     = (MemTidChannels > 1) ? $clog2(MemTidChannels) : 1;

    typedef logic [MemTidWidth-1:0]      tid_t;
    typedef logic [MemTidChIdxWidth-1:0] ch_idx_t;
    typedef logic [MemTidWidth:0]        tid_cnt_t;

    // The cap must be reachable with the available TID space and never zero.
    function automatic bit max_outstanding_ok(input int unsigned max_out,
                                              input int unsigned tid_width);
        return (max_out >= 1) && (max_out <= (32'd1 << tid_width));
    endfunction

    function automatic bit nr_channels_ok(input int unsigned nr_channels);
        return (nr_channels >= 1) && (nr_channels <= 8);
    endfunction

endpackage

// File: rtl/mem_tid_allocator_if.sv
// Allocation / release handshake bundle between requesters and the TID allocator.
interface mem_tid_allocator_if #(
    parameter int unsigned NrChannels = 2,
    parameter int unsigned TidWidth   = 4,
    parameter int unsigned ChIdxWidth = (NrChannels > 1) ? $clog2(NrChannels) : 1
);
    logic [NrChannels-1:0] alloc_valid_i;
    logic [NrChannels-1:0] alloc_ready_o;
    logic [TidWidth-1:0]   alloc_tid_o;
    logic                  drain_i;
    logic                  release_valid_i;
    logic [TidWidth-1:0]   release_tid_i;
    logic [ChIdxWidth-1:0] release_owner_o;

    modport slave (
        input  alloc_valid_i, drain_i, release_valid_i, release_tid_i,
        output alloc_ready_o, alloc_tid_o, release_owner_o
    );

    modport master (
        output alloc_valid_i, drain_i, release_valid_i, release_tid_i,
        input  alloc_ready_o, alloc_tid_o, release_owner_o
    );
endinterface

// File: rtl/mem_tid_rr_arb.sv
// Round-robin arbiter: one-hot grant starting at the pointer, pointer advances past the winner.
module mem_tid_rr_arb #(
    parameter int unsigned NrChannels = 2,
    parameter int unsigned ChIdxWidth = (NrChannels > 1) ? $clog2(NrChannels) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [NrChannels-1:0] req_i,
    output logic [NrChannels-1:0] gnt_o,
    output logic [ChIdxWidth-1:0] idx_o
);
    logic [ChIdxWidth-1:0] ptr_q;
    logic [ChIdxWidth-1:0] ptr_d;
    logic                  found;

    // Scan requesters in rotated order from the pointer; first one wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NrChannels; k++) begin
            for (int unsigned c = 0; c < NrChannels; c++) begin
                if (en_i && !found && req_i[c] &&
                    (((int'(ptr_q) + k) % NrChannels) == c)) begin
                    gnt_o[c] = 1'b1;
                    idx_o    = ChIdxWidth'(c);
                    found    = 1'b1;
                end
            end
        end
        ptr_d = found ? ChIdxWidth'((int'(idx_o) + 1) % NrChannels) : ptr_q;
    end

    // Pointer holds unless a grant was issued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/mem_tid_allocator.sv
// Shared transaction-ID allocator: arbitrates channels, hands out the lowest free TID,
// tracks the owning channel per TID and enforces an outstanding cap.
module mem_tid_allocator
    import mem_tid_pkg::*;
#(
    parameter int unsigned NrChannels     = MemTidChannels,
    parameter int unsigned TidWidth       = MemTidWidth,
    parameter int unsigned MaxOutstanding = MaxOutstandingStores,
    parameter int unsigned ChIdxWidth     = (NrChannels > 1) ? $clog2(NrChannels) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_tid_allocator_if.slave  bus,
    output logic [TidWidth:0]   outstanding_o,
    output logic                full_o,
    output logic                idle_o,
    output logic                err_double_release_o
);
    localparam int unsigned NrTids = 1 << TidWidth;

    if (!max_outstanding_ok(MaxOutstanding, TidWidth)) begin : g_bad_max_outstanding
        $error("MaxOutstanding must be within 1..2**TidWidth");
    end
    if (!nr_channels_ok(NrChannels)) begin : g_bad_nr_channels
        $error("NrChannels must be within 1..8");
    end

    logic [NrTids-1:0]     free_q;
    logic [ChIdxWidth-1:0] owner_q [NrTids];
    logic [TidWidth:0]     cnt_q;
    logic [TidWidth:0]     cnt_d;
    logic                  err_q;

    logic                  grant_en;
    logic [NrChannels-1:0] gnt;
    logic [ChIdxWidth-1:0] win_idx;
    logic [TidWidth-1:0]   free_tid;
    logic                  free_found;
    logic                  alloc_fire;
    logic                  release_hit;
    logic                  release_miss;

    assign full_o   = (cnt_q == (TidWidth + 1)'(MaxOutstanding));
    assign idle_o   = (cnt_q == '0);
    // Grants are suppressed while reset is held so the ready lines read 0 asynchronously.
    assign grant_en = !rst_i && !bus.drain_i && !full_o && (|free_q);

    mem_tid_rr_arb #(
        .NrChannels (NrChannels),
        .ChIdxWidth (ChIdxWidth)
    ) i_rr_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (grant_en),
        .req_i (bus.alloc_valid_i),
        .gnt_o (gnt),
        .idx_o (win_idx)
    );

    // Lowest-index free TID from the registered bitmap, so a same-cycle release is not reissued.
    always_comb begin
        free_tid   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < NrTids; i++) begin
            if (!free_found && free_q[i]) begin
                free_tid   = TidWidth'(i);
                free_found = 1'b1;
            end
        end
    end

    assign alloc_fire   = |gnt;
    assign release_hit  = bus.release_valid_i && !free_q[bus.release_tid_i];
    assign release_miss = bus.release_valid_i &&  free_q[bus.release_tid_i];

    assign bus.alloc_ready_o      = gnt;
    assign bus.alloc_tid_o        = free_tid;
    assign bus.release_owner_o    = owner_q[bus.release_tid_i];
    assign outstanding_o          = cnt_q;
    assign err_double_release_o   = err_q;

    // Net counter change: an allocation and a release in the same cycle cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (alloc_fire && !release_hit)      cnt_d = cnt_q + 1'b1;
        else if (!alloc_fire && release_hit) cnt_d = cnt_q - 1'b1;
    end

    // Bitmap, owner table, counter and error pulse update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            free_q  <= '1;
            owner_q <= '{default: '0};
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (alloc_fire) begin
                free_q[free_tid]  <= 1'b0;
                owner_q[free_tid] <= win_idx;
            end
            if (release_hit) free_q[bus.release_tid_i] <= 1'b1;
            cnt_q <= cnt_d;
            err_q <= release_miss;
        end
    end
endmodule

// File: tb/tb_mem_tid_allocator.sv
// Scoreboard bench for mem_tid_allocator (2 channels, 4-bit TIDs, cap 7).
module tb_mem_tid_allocator;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [4:0] outstanding_o;
    logic       full_o;
    logic       idle_o;
    logic       err_double_release_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int ch;
        int tid;
    } exp_t;
    exp_t exp_q[$];

    mem_tid_allocator_if #(.NrChannels(2), .TidWidth(4)) bus ();

    mem_tid_allocator #(
        .NrChannels     (2),
        .TidWidth       (4),
        .MaxOutstanding (7)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .bus                  (bus),
        .outstanding_o        (outstanding_o),
        .full_o               (full_o),
        .idle_o               (idle_o),
        .err_double_release_o (err_double_release_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, queue the expected grant, stop at the falling edge.
    task automatic cyc(input logic [1:0] v, input logic d, input logic rv, input logic [3:0] rt,
                       input bit eg, input int ech, input int etid);
        exp_t e;
        @(posedge clk_i);
        #1;
        bus.alloc_valid_i   = v;
        bus.drain_i         = d;
        bus.release_valid_i = rv;
        bus.release_tid_i   = rt;
        if (eg) begin
            e.ch  = ech;
            e.tid = etid;
            exp_q.push_back(e);
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        #2;
        rst_i               = 1'b1;
        bus.alloc_valid_i   = 2'b11;
        bus.drain_i         = 1'b0;
        bus.release_valid_i = 1'b0;
        bus.release_tid_i   = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", int'(bus.alloc_ready_o), 0);
        chk("rst_outstanding", int'(outstanding_o), 0);
        chk("rst_idle", int'(idle_o), 1);
        chk("rst_full", int'(full_o), 0);
        chk("rst_err", int'(err_double_release_o), 0);
        bus.alloc_valid_i = 2'b00;
        rst_i             = 1'b0;
    endtask

    // Monitor: pop one expectation per observed grant and check the bitmap/counter invariant.
    initial begin
        exp_t       e;
        logic [1:0] exp_rdy;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                checks++;
                if (int'(outstanding_o) != 16 - $countones(dut.free_q)) begin
                    failures++;
                    $display("FAIL invariant outstanding=%0d expected=%0d", outstanding_o,
                             16 - $countones(dut.free_q));
                end
            end
            if (bus.alloc_ready_o != 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_grant ready=%b tid=%0d expected=no_grant",
                             bus.alloc_ready_o, bus.alloc_tid_o);
                end else begin
                    e       = exp_q.pop_front();
                    exp_rdy = 2'b01 << e.ch;
                    if (bus.alloc_ready_o != exp_rdy || int'(bus.alloc_tid_o) != e.tid) begin
                        failures++;
                        $display("FAIL grant ready=%b tid=%0d expected ready=%b tid=%0d",
                                 bus.alloc_ready_o, bus.alloc_tid_o, exp_rdy, e.tid);
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.alloc_valid_i   = 2'b00;
        bus.drain_i         = 1'b0;
        bus.release_valid_i = 1'b0;
        bus.release_tid_i   = '0;

        // Single channel: consecutive lowest TIDs.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(2'b01, 0, 0, 4'd0, 1, 0, i);
        cyc(2'b00, 0, 0, 4'd1, 0, 0, 0);
        chk("s1_outstanding", int'(outstanding_o), 3);
        chk("s1_owner_tid1", int'(bus.release_owner_o), 0);
        chk("s1_idle", int'(idle_o), 0);

        // Two channels alternate until the cap.
        do_reset();
        for (int i = 0; i < 7; i++) cyc(2'b11, 0, 0, 4'd0, 1, i % 2, i);
        cyc(2'b11, 0, 0, 4'd0, 0, 0, 0);
        chk("s2_full", int'(full_o), 1);
        chk("s2_outstanding", int'(outstanding_o), 7);
        chk("s2_ready", int'(bus.alloc_ready_o), 0);

        // Release at full: no grant this cycle, TID 3 reissued to ch1 next cycle.
        cyc(2'b11, 0, 1, 4'd3, 0, 0, 0);
        chk("s3_owner_tid3", int'(bus.release_owner_o), 1);
        chk("s3_ready_at_full", int'(bus.alloc_ready_o), 0);
        cyc(2'b11, 0, 0, 4'd0, 1, 1, 3);
        chk("s3_outstanding_after_rel", int'(outstanding_o), 6);
        cyc(2'b00, 0, 0, 4'd0, 0, 0, 0);
        chk("s3_outstanding_refill", int'(outstanding_o), 7);
        chk("s3_full_again", int'(full_o), 1);

        // Same-cycle alloc and release: pre-release bitmap is used.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(2'b01, 0, 0, 4'd0, 1, 0, i);
        cyc(2'b01, 0, 1, 4'd0, 1, 0, 5);
        chk("s4_outstanding_pre", int'(outstanding_o), 5);
        cyc(2'b01, 0, 0, 4'd0, 1, 0, 0);
        chk("s4_outstanding_same", int'(outstanding_o), 5);
        cyc(2'b00, 0, 0, 4'd0, 0, 0, 0);
        chk("s4_outstanding_post", int'(outstanding_o), 6);

        // Release of a never-allocated TID.
        cyc(2'b00, 0, 1, 4'd9, 0, 0, 0);
        chk("s5_err_same_cycle", int'(err_double_release_o), 0);
        cyc(2'b00, 0, 0, 4'd0, 0, 0, 0);
        chk("s5_err_pulse", int'(err_double_release_o), 1);
        chk("s5_outstanding", int'(outstanding_o), 6);
        cyc(2'b00, 0, 0, 4'd0, 0, 0, 0);
        chk("s5_err_cleared", int'(err_double_release_o), 0);
        cyc(2'b01, 0, 0, 4'd0, 1, 0, 6);
        cyc(2'b00, 0, 0, 4'd0, 0, 0, 0);
        chk("s5_outstanding_full", int'(outstanding_o), 7);
        chk("s5_full", int'(full_o), 1);

        // Drain blocks grants, releases still retire, then async reset mid-operation.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(2'b10, 0, 0, 4'd0, 1, 1, i);
        cyc(2'b11, 1, 0, 4'd0, 0, 0, 0);
        chk("s6_outstanding_drain", int'(outstanding_o), 4);
        for (int i = 0; i < 4; i++) begin
            cyc(2'b11, 1, 1, 4'(i), 0, 0, 0);
            if (i == 2) chk("s6_owner_tid2", int'(bus.release_owner_o), 1);
        end
        cyc(2'b11, 1, 0, 4'd0, 0, 0, 0);
        chk("s6_idle", int'(idle_o), 1);
        chk("s6_outstanding_zero", int'(outstanding_o), 0);
        cyc(2'b11, 0, 0, 4'd0, 1, 0, 0);
        cyc(2'b11, 0, 0, 4'd0, 1, 1, 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("s6_async_ready", int'(bus.alloc_ready_o), 0);
        chk("s6_async_outstanding", int'(outstanding_o), 0);
        chk("s6_async_idle", int'(idle_o), 1);
        chk("s6_async_full", int'(full_o), 0);
        repeat (2) @(posedge clk_i);
        #1;
        bus.alloc_valid_i = 2'b00;
        rst_i             = 1'b0;
        cyc(2'b01, 0, 0, 4'd0, 1, 0, 0);
        cyc(2'b00, 0, 0, 4'd0, 0, 0, 0);
        chk("s6_outstanding_after_rst", int'(outstanding_o), 1);

        chk("exp_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_tid_allocator.md
Name: mem_tid_allocator

Overview:
- Parametrised memory transaction-ID allocator for the cache subsystem's NoC side.
- Generalises fixed outstanding-store and load-buffer limits into one shared tracker for several request channels (e.g. load, store, PTW, AMO).
- Round-robin arbitrates requesters, hands out the lowest free TID and enforces a programmable outstanding cap.
- Records which channel owns each TID so responses can be routed back, and frees TIDs on release.

Parameters:
- NrChannels, 2, number of requesting channels (1..8).
- TidWidth, 4, TID width; NrTids = 2**TidWidth.
- MaxOutstanding, 7, cap on simultaneously allocated TIDs (1..NrTids); static check fails elaboration otherwise.
- ChIdxWidth, max(1,$clog2(NrChannels)), derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- alloc_valid_i  in  NrChannels  per-channel allocation request
- alloc_ready_o  out  NrChannels  one-hot grant; at most one bit set
- alloc_tid_o  out  TidWidth  TID granted this cycle; valid when any alloc_ready_o bit is set
- drain_i  in  1  blocks new allocations; releases still accepted
- release_valid_i  in  1  response/completion frees a TID
- release_tid_i  in  TidWidth  TID being freed
- release_owner_o  out  ChIdxWidth  owner channel of release_tid_i (combinational table read)
- outstanding_o  out  TidWidth+1  number of allocated TIDs
- full_o  out  1  outstanding_o == MaxOutstanding
- idle_o  out  1  outstanding_o == 0
- err_double_release_o  out  1  one-cycle pulse: released TID was not allocated

Behaviour:
- Reset (async assert, sync-safe deassert):
  - free bitmap all ones; owner table 0; outstanding_o 0.
  - Round-robin pointer 0; err_double_release_o 0.
  - idle_o 1, full_o 0; alloc_ready_o 0 while rst_i high.
- Grant eligibility: !drain_i && !full_o && any free bit. Otherwise all alloc_ready_o are 0.
- Arbitration:
  - Round-robin over the alloc_valid_i bits, starting at the pointer.
  - Winner gets alloc_ready_o high in the same cycle (combinational, zero latency).
  - After a grant, the pointer moves to winner+1 mod NrChannels.
  - With no grant, the pointer holds.
- TID choice: lowest-index set bit of the free bitmap, taken from the pre-update bitmap.
- Handshake:
  - Allocation commits on the edge where alloc_valid_i[c] && alloc_ready_o[c].
  - On commit: clear the free bit, write owner[tid] = c, increment the counter.
  - Requesters may drop valid without a grant; no state changes.
- Release with release_valid_i:
  - If the TID is allocated: set its free bit at the edge and decrement the counter.
  - If the TID is already free: no state change, and err_double_release_o pulses the next cycle.
- Simultaneous alloc and release in one cycle:
  - Both commit; the counter is unchanged.
  - A TID released this cycle is not reissued until the next cycle, because the allocator uses the pre-release bitmap.
  - At full_o, a same-cycle release does not enable a grant; the grant happens one cycle later.
- Counter stays within 0..MaxOutstanding.
- Counter invariant: outstanding_o == NrTids - popcount(free); the bench checks it as an assertion.
- drain_i has no effect on the pointer or on releases. Drain completes when idle_o rises.
- Reset mid-operation: all in-flight TIDs are forgotten. The surrounding NoC must be reset in the same domain.
- release_owner_o reads the table even for free TIDs; the returned value is then meaningless.

Decomposition:
- Shared package mem_tid_pkg:
  - tid_t, ch_idx_t and the outstanding count type, all parametrised via localparams drawn from the cva6 config (MemTidWidth, MaxOutstandingStores).
  - A static-check function for MaxOutstanding <= 2**TidWidth.
- Use common_cells lzc for the lowest-free-TID search.
- One natural local sub-module: mem_tid_rr_arb (round-robin arbiter with pointer register, NrChannels param, one-hot gnt output).

Test Plan:
- Reset, then ch0 valid for 3 cycles (TidWidth=4, Max=7) -> TIDs 0,1,2 granted on consecutive cycles; outstanding_o 3; release_owner_o for TID 1 = 0.
- ch0 and ch1 both valid continuously -> grants alternate ch0,ch1,ch0,…; TIDs 0..6 issued; at 7 allocated full_o=1 and all alloc_ready_o=0.
- At full, release TID 3 while both channels valid -> no grant that cycle; next cycle TID 3 granted to the channel the pointer selects; outstanding_o back to 7.
- With 5 outstanding, alloc and release TID 0 in the same cycle -> the new grant gets the lowest pre-release free TID (5), not 0; outstanding_o stays 5; TID 0 issued on the following grant.
- Release of never-allocated TID 9 -> err_double_release_o pulses exactly one cycle later; bitmap and count unchanged.
- drain_i high with 4 outstanding and valids asserted -> no grants; four releases -> idle_o=1; drain_i low -> grants resume, with rst_i asserted mid-sequence returning all outputs to reset values asynchronously.
